neuron_classifier: RTL and testbench
====================================

// Module: neuron_classifier
// PURPOSE
//  Inference-side counterpart of the neuron trainer datapath: snapshots trained w1/w2/b, streams n samples (x1,x2)
//  through a 2-stage MAC pipeline, emits one class label per sample in trainer t-encoding.
//  Sits between the weight registers of the trainer and the sample/result stream of the top level.
// PARAMETERS
//  XW    7   sample width, signed two's complement
//  WW    14  weight/bias width, signed two's complement
//  CNTW  32  sample-count / n width
// PORTS
//  clk       in   1     clock, rising edge
//  rst       in   1     asynchronous active-low reset
//  start     in   1     pulse: latch nInput, w1, w2, b; begin run
//  nInput    in   CNTW  number of samples in this run
//  w1, w2, b in   WW    trained weights/bias (sampled only on accepted start)
//  x1Input   in   XW    sample feature 1
//  x2Input   in   XW    sample feature 2
//  inValid   in   1     sample present
//  inReady   out  1     sample accepted when inValid & inReady
//  yValid    out  1     class output valid
//  yReady    in   1     consumer takes class when yValid & yReady
//  yClass    out  2     2'b01 = +1 (score >= 0), 2'b11 = -1 (score < 0)
//  busy      out  1     high in RUN
//  done      out  1     high in DONE, until next start
//  count     out  CNTW  classes delivered this run
// BEHAVIOUR
//  Reset (async, rst=0): state IDLE; inReady=0, yValid=0, yClass=2'b00, busy=0, done=0, count=0; pipeline valids 0.
//  FSM: IDLE --start--> RUN (or DONE if nInput==0); RUN --count reaches n--> DONE; DONE --start--> RUN/DONE.
//  start honoured only in IDLE/DONE; ignored in RUN. Accepted start clears count, accepted counter and done.
//  Arithmetic: p1=x1*w1, p2=x2*w2 signed 21b; score = p1+p2+sext(b) signed 22b; no overflow possible.
//  yClass = score[21] ? 2'b11 : 2'b01 (score==0 -> +1).
//  Pipeline: S1 registers p1,p2,b; S2 registers yClass/yValid. Latency 2 cycles accept->yValid, no stall.
//  advance = !yValid | yReady; both stages move only on advance (S1 bubble fills when S2 empty).
//  inReady = RUN & advance & (accepted < n). Never accepts more than n samples; inValid while !inReady ignored.
//  count increments on each yValid&yReady; when count becomes n -> DONE next cycle, inReady=0, pipeline empty.
//  Full throughput: one sample/cycle when yReady held high. Backpressure: no sample dropped or duplicated.
//  yClass held stable while yValid & !yReady.
//  Reset mid-run: all state discarded immediately; no partial results emitted after rst deasserts.
//  Weight ports may change during RUN without effect (snapshot semantics).
// CONFIGURATION
//  NEURON_SCORE_EN defined: extra output yScore[21:0] = registered signed score, aligned with yValid/yClass,
//   reset 0, held under stall.
//  Undefined: port absent; score truncated to sign after S1 sum; all other behaviour identical.
// STRUCTURE
//  Package neuron_pkg: XW/WW/CNTW/SW(=22) constants, T_POS=2'b01, T_NEG=2'b11, state enum
//   {ST_IDLE, ST_RUN, ST_DONE}.
//  Sub-module neuron_mac: S1 signed multiply stage with valid/advance (instanced once, 2 products).
//  FSM, counters, S2 and handshake in neuron_classifier.
// TESTING
//  1 w1=2,w2=-3,b=1,n=2; samples (5,3),(1,4), yReady=1 -> yClass 01 then 11, yValid 2 cyc after each accept,
//    count=2, done=1.
//  2 nInput=0 start -> DONE next cycle, inReady never high, count=0, yValid never high.
//  3 n=8, inValid=1, yReady=0 for 5 cycles after first accept -> inReady drops, yClass stable, after release
//    all 8 labels in order.
//  4 w1=w2=-8192,b=8191, x1=x2=-64 -> score 1056767, yClass 01; w1=8191,x1=-64,w2=0,b=0 -> yClass 11.
//  5 score==0 (w1=1,x1=1,b=-1,w2=0) -> yClass 01.
//  6 rst low mid-run with 2 in flight -> outputs at reset values within same cycle; new start n=1 works normally.
//  7 (NEURON_SCORE_EN) case 1 -> yScore 2 then -9, aligned with yValid.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared constants, label encodings and FSM state type for the neuron classifier.
`timescale 1ns/1ps

package neuron_pkg;

    localparam int XW   = 7;
    localparam int WW   = 14;
    localparam int CNTW = 32;
    localparam int PW   = XW + WW;
    localparam int SW   = 22;

    localparam logic [1:0] T_POS = 2'b01;
    localparam logic [1:0] T_NEG = 2'b11;
    localparam logic [1:0] T_RST = 2'b00;

    localparam logic signed [SW-1:0] SCORE_ZERO = '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    // Zero scores are labelled +1, so only a strictly negative score maps to -1.
    function automatic logic [1:0] label_of(input logic neg);
        return neg ? T_NEG : T_POS;
    endfunction

endpackage

// File: rtl/neuron_mac.sv
// First pipeline stage: registers both signed products and the bias.
// It only moves when the output stage can take its contents.
`timescale 1ns/1ps

module neuron_mac
    import neuron_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 advance,
    input  logic                 in_valid,
    input  logic signed [XW-1:0] x1,
    input  logic signed [XW-1:0] x2,
    input  logic signed [WW-1:0] w1,
    input  logic signed [WW-1:0] w2,
    input  logic signed [WW-1:0] b,
    output logic                 out_valid,
    output logic signed [PW-1:0] p1,
    output logic signed [PW-1:0] p2,
    output logic signed [WW-1:0] b_out
);

    // Product registers; the data is held when a bubble passes through.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            p1        <= '0;
            p2        <= '0;
            b_out     <= '0;
        end else if (advance) begin
            out_valid <= in_valid;
            if (in_valid) begin
                p1    <= PW'(x1) * PW'(w1);
                p2    <= PW'(x2) * PW'(w2);
                b_out <= b;
            end
        end
    end

endmodule

// File: rtl/neuron_classifier.sv
// Inference datapath: snapshots w1/w2/b on start, then streams n samples
// through a two-stage MAC pipeline. Each sample produces one +1/-1 label.
// Optional build macro NEURON_SCORE_EN adds the yScore output. This output
// carries the registered signed score.
`timescale 1ns/1ps

module neuron_classifier
    import neuron_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CNTW-1:0]        nInput,
    input  logic signed [WW-1:0]   w1,
    input  logic signed [WW-1:0]   w2,
    input  logic signed [WW-1:0]   b,
    input  logic signed [XW-1:0]   x1Input,
    input  logic signed [XW-1:0]   x2Input,
    input  logic                   inValid,
    output logic                   inReady,
    output logic                   yValid,
    input  logic                   yReady,
    output logic [1:0]             yClass,
    output logic                   busy,
    output logic                   done,
    output logic [CNTW-1:0]        count
`ifdef NEURON_SCORE_EN
   ,output logic signed [SW-1:0]   yScore
`endif
);

    state_t state, state_next;

    logic [CNTW-1:0]       n_reg;
    logic [CNTW-1:0]       accepted;
    logic signed [WW-1:0]  w1_reg, w2_reg, b_reg;

    logic                  advance, accept, deliver, last_deliver, start_take;

    logic                  s1_valid;
    logic signed [PW-1:0]  p1, p2;
    logic signed [WW-1:0]  b_s1;
    logic signed [SW-1:0]  score_sum;
    logic                  score_neg;

    assign advance      = !yValid || yReady;
    assign deliver      = yValid && yReady;
    assign last_deliver = deliver && ((count + CNTW'(1)) == n_reg);
    assign accept       = inValid && inReady;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and outputs decoded from the state.
    always_comb begin
        state_next = state;
        start_take = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        inReady    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                done = (state == ST_DONE);
                if (start) begin
                    start_take = 1'b1;
                    state_next = (nInput == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                busy    = 1'b1;
                inReady = advance && (accepted < n_reg);
                if (last_deliver) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Run snapshot and progress counters; weight ports are ignored outside an accepted start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_reg    <= '0;
            w1_reg   <= '0;
            w2_reg   <= '0;
            b_reg    <= '0;
            count    <= '0;
            accepted <= '0;
        end else if (start_take) begin
            n_reg    <= nInput;
            w1_reg   <= w1;
            w2_reg   <= w2;
            b_reg    <= b;
            count    <= '0;
            accepted <= '0;
        end else begin
            if (accept) begin
                accepted <= accepted + CNTW'(1);
            end
            if (deliver) begin
                count <= count + CNTW'(1);
            end
        end
    end

    neuron_mac u_mac (
        .clk       (clk),
        .rst       (rst),
        .advance   (advance),
        .in_valid  (accept),
        .x1        (x1Input),
        .x2        (x2Input),
        .w1        (w1_reg),
        .w2        (w2_reg),
        .b         (b_reg),
        .out_valid (s1_valid),
        .p1        (p1),
        .p2        (p2),
        .b_out     (b_s1)
    );

    // 22 bits hold the worst case |p1|+|p2|+|b| without overflow.
    assign score_sum = SW'(p1) + SW'(p2) + SW'(b_s1);
    assign score_neg = score_sum < SCORE_ZERO;

    // Output stage: the label is held while the consumer stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            yValid <= 1'b0;
            yClass <= T_RST;
        end else if (advance) begin
            yValid <= s1_valid;
            if (s1_valid) begin
                yClass <= label_of(score_neg);
            end
        end
    end

`ifdef NEURON_SCORE_EN
    // Full score, registered alongside the label.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            yScore <= '0;
        end else if (advance && s1_valid) begin
            yScore <= score_sum;
        end
    end
`endif

endmodule

// File: tb/tb_neuron_classifier.sv
// Scoreboard bench for neuron_classifier: the stimulus side pushes the
// labels/scores from the reference model, and the monitor compares them
// against the output stream.
`timescale 1ns/1ps

module tb_neuron_classifier;
    import neuron_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  start = 1'b0;
    logic [CNTW-1:0]       nInput = '0;
    logic signed [WW-1:0]  w1 = '0, w2 = '0, b = '0;
    logic signed [XW-1:0]  x1Input = '0, x2Input = '0;
    logic                  inValid = 1'b0;
    logic                  inReady;
    logic                  yValid;
    logic                  yReady = 1'b0;
    logic [1:0]            yClass;
    logic                  busy, done;
    logic [CNTW-1:0]       count;
`ifdef NEURON_SCORE_EN
    logic signed [SW-1:0]  yScore;
`endif

    neuron_classifier dut (
        .clk(clk), .rst(rst), .start(start), .nInput(nInput),
        .w1(w1), .w2(w2), .b(b), .x1Input(x1Input), .x2Input(x2Input),
        .inValid(inValid), .inReady(inReady), .yValid(yValid), .yReady(yReady),
        .yClass(yClass), .busy(busy), .done(done), .count(count)
`ifdef NEURON_SCORE_EN
       ,.yScore(yScore)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    logic [1:0] q_cls[$];
    int         q_score[$];
    int         q_cyc[$];

    int  sx1[$];
    int  sx2[$];
    bit  chk_lat    = 1'b0;
    int  rdy_mode   = 0;
    int  stall_left = 0;
    bit  stall_first = 1'b0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer dot product plus bias; the label is +1 when the score is non-negative.
    function automatic int ref_score(input int xa, input int xb, input int wa, input int wb, input int bb);
        return xa * wa + xb * wb + bb;
    endfunction

    // Consumer ready pattern: always ready, random, or a scripted stall.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: yReady = 1'b1;
            1: yReady = ($urandom_range(0, 2) != 0);
            default: begin
                if (stall_left > 0) begin
                    yReady = 1'b0;
                    stall_left--;
                end else begin
                    yReady = 1'b1;
                end
            end
        endcase
    end

    // Monitor: whenever a label is presented it must match the head of the scoreboard.
    logic prev_stall = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            if (prev_stall) check("stall_hold_valid", yValid, 1);
            if (yValid && !yReady) check("inready_under_stall", inReady, 0);
            if (yValid) begin
                if (q_cls.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_output: got class %0d with empty scoreboard (cycle %0d)", yClass, cyc);
                end else begin
                    check("class", yClass, q_cls[0]);
`ifdef NEURON_SCORE_EN
                    check("score", yScore, q_score[0]);
`endif
                    if (chk_lat && q_cyc[0] >= 0) begin
                        check("latency", cyc, q_cyc[0] + 2);
                        q_cyc[0] = -1;
                    end
                    if (yReady) begin
                        void'(q_cls.pop_front());
                        void'(q_score.pop_front());
                        void'(q_cyc.pop_front());
                    end
                end
            end
            prev_stall = yValid && !yReady;
        end else begin
            prev_stall = 1'b0;
        end
    end

    int cur_w1, cur_w2, cur_b;

    task automatic do_start(input int n, input int a, input int c, input int d);
        @(posedge clk); #1;
        nInput = CNTW'(n);
        w1 = WW'(a); w2 = WW'(c); b = WW'(d);
        start = 1'b1;
        cur_w1 = a; cur_w2 = c; cur_b = d;
        @(posedge clk); #1;
        start = 1'b0;
        w1 = WW'($urandom); w2 = WW'($urandom); b = WW'($urandom);
        nInput = CNTW'($urandom_range(1, 50));
    endtask

    task automatic feed(input int n, input bit rand_valid);
        int idx = 0;
        int guard = 0;
        int s;
        while (idx < n && guard < 3000) begin
            @(posedge clk); #1;
            inValid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            x1Input = XW'(sx1[idx]);
            x2Input = XW'(sx2[idx]);
            @(negedge clk);
            if (inValid && inReady) begin
                s = ref_score(sx1[idx], sx2[idx], cur_w1, cur_w2, cur_b);
                q_cls.push_back(s >= 0 ? T_POS : T_NEG);
                q_score.push_back(s);
                q_cyc.push_back(cyc);
                if (idx == 0 && stall_first) stall_left = 5;
                idx++;
            end
            guard++;
        end
        if (idx < n) check("feed_timeout_accepted", idx, n);
        @(posedge clk); #1;
        inValid = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int guard = 0;
        inValid = 1'b1;
        @(negedge clk);
        while (!done && guard < 3000) begin
            check("no_over_accept", inReady, 0);
            @(negedge clk);
            guard++;
        end
        check("done", done, 1);
        check("count", count, n);
        check("busy_after_done", busy, 0);
        check("scoreboard_drained", q_cls.size(), 0);
        inValid = 1'b0;
    endtask

    task automatic run(input int n, input int a, input int c, input int d, input bit rand_valid);
        do_start(n, a, c, d);
        feed(n, rand_valid);
        wait_done(n);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_inReady"}, inReady, 0);
        check({tag, "_yValid"},  yValid, 0);
        check({tag, "_yClass"},  yClass, 0);
        check({tag, "_busy"},    busy, 0);
        check({tag, "_done"},    done, 0);
        check({tag, "_count"},   count, 0);
`ifdef NEURON_SCORE_EN
        check({tag, "_yScore"},  yScore, 0);
`endif
    endtask

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        // Directed: two samples, labels +1 then -1, two-cycle latency.
        rdy_mode = 0; chk_lat = 1'b1;
        sx1 = '{5, 1}; sx2 = '{3, 4};
        run(2, 2, -3, 1, 1'b0);

        // Zero-length run goes straight to DONE and never accepts or emits anything.
        do_start(0, 3, 3, 3);
        @(negedge clk);
        check("n0_done", done, 1);
        check("n0_count", count, 0);
        inValid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("n0_inReady", inReady, 0);
            check("n0_yValid", yValid, 0);
            @(negedge clk);
        end
        inValid = 1'b0;

        // Backpressure: the consumer stalls for five cycles after the first accept.
        chk_lat = 1'b0; rdy_mode = 2; stall_first = 1'b1;
        sx1 = {}; sx2 = {};
        for (int i = 0; i < 8; i++) begin
            sx1.push_back($urandom_range(0, 127) - 64);
            sx2.push_back($urandom_range(0, 127) - 64);
        end
        run(8, 37, -111, 250, 1'b0);
        stall_first = 1'b0; rdy_mode = 0; chk_lat = 1'b1;

        // Extremes and zero score.
        sx1 = '{-64}; sx2 = '{-64};
        run(1, -8192, -8192, 8191, 1'b0);
        sx1 = '{-64}; sx2 = '{17};
        run(1, 8191, 0, 0, 1'b0);
        sx1 = '{1}; sx2 = '{-50};
        run(1, 1, 0, -1, 1'b0);

        // Reset with two samples in flight.
        sx1 = '{10, -20, 30, 40}; sx2 = '{1, 2, 3, 4};
        do_start(4, 100, 200, -300);
        feed(2, 1'b0);
        #2 rst = 1'b0;
        #1 check_reset_outputs("midrun_reset");
        q_cls.delete(); q_score.delete(); q_cyc.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_reset_yValid", yValid, 0);
        end
        sx1 = '{-7}; sx2 = '{9};
        run(1, 500, -600, 42, 1'b0);

        // Randomized runs with random valid and ready patterns.
        chk_lat = 1'b0; rdy_mode = 1;
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 12);
            sx1 = {}; sx2 = {};
            for (int i = 0; i < n; i++) begin
                sx1.push_back($urandom_range(0, 127) - 64);
                sx2.push_back($urandom_range(0, 127) - 64);
            end
            run(n, $urandom_range(0, 16383) - 8192, $urandom_range(0, 16383) - 8192,
                $urandom_range(0, 16383) - 8192, 1'b1);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
